input_command_parser: RTL and testbench
=======================================

Name: input_command_parser

Overview:
- Receive-side counterpart of the output value reporter: consumes bytes from the UART RX path and decodes ASCII host commands into LED and element register writes.
- Sits between the UART receiver byte stream and the LED/element drive logic.
- Accepts one byte per enabled cycle with no back-pressure.
- Reports malformed commands via a one-cycle error pulse.

Parameters:
- DATA_WIDTH, 8, width of rx_data; only bits [7:0] are decoded, any upper bits are ignored.
- LED_COUNT, 16, width of the LED register; LED_DIGITS = ceil(LED_COUNT/4) hex digits.
- ELEMENT_COUNT, 12, width of the element register; ELEM_DIGITS = ceil(ELEMENT_COUNT/4) hex digits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous active-high reset.
- ena  input  1  global enable; when low, all state and outputs hold and rx_valid is ignored.
- rx_data  input  DATA_WIDTH  received byte.
- rx_valid  input  1  rx_data valid this cycle; byte consumed on any cycle with ena=1.
- led_data  output  LED_COUNT  last committed LED value.
- led_update  output  1  one-cycle pulse when led_data changes due to a commit.
- element_data  output  ELEMENT_COUNT  last committed element value.
- element_update  output  1  one-cycle pulse when element_data is committed.
- parse_error  output  1  one-cycle pulse on a malformed byte.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (sync, reset=1 at a clk edge):
  - state=IDLE.
  - led_data, element_data and the accumulator are cleared to 0.
  - All pulses are 0; busy=0.
  - Reset overrides ena and any in-progress command, which is dropped with no commit and no error.
- Command grammar: 'L'|'l' followed by LED_DIGITS hex digits, then a terminator; or 'E'|'e' followed by ELEM_DIGITS hex digits, then a terminator.
  - Hex digit: 0-9, A-F, a-f.
  - Terminator: CR (0x0D) or LF (0x0A).
- States:
  - IDLE:
    - 'L'/'l' sets target=LED, digit counter=LED_DIGITS, clears the accumulator, goes to DIGITS.
    - 'E'/'e' does the same with target=ELEM and counter=ELEM_DIGITS.
    - CR, LF and space (0x20) are ignored silently.
    - Any other byte pulses parse_error and goes to DISCARD.
  - DIGITS:
    - A hex byte makes acc = {acc[W-5:0], nibble} and decrements the counter; when the counter reaches 0, go to TERM.
    - A terminator pulses parse_error (short command) and goes to IDLE.
    - Any other byte pulses parse_error and goes to DISCARD.
  - TERM:
    - A terminator commits: the target register takes acc truncated to the register width, the matching *_update pulse fires, then go to IDLE.
    - Any other byte (extra digit included) pulses parse_error and goes to DISCARD.
  - DISCARD: ignore all bytes until a terminator, then go to IDLE. No further error pulses; no commit.
- Truncation: when a register width is not a multiple of 4, the high bits of the first digit are dropped.
- Timing: outputs are registered.
  - The commit value and *_update are visible in the cycle after the terminator byte is sampled.
  - parse_error is visible in the cycle after the offending byte is sampled.
  - Pulses last exactly one clk cycle when ena=1.
- A commit fires *_update even if the new value equals the old value.
- ena=0: the FSM, accumulator and registers hold. Pulses deassert on the next edge.
- busy=1 in DIGITS, TERM and DISCARD.
- Back-to-back bytes on consecutive cycles are fully supported, including a new command immediately after a terminator.

Test Plan:
- Reset with rx_valid=1 and byte 'L' -> after release, led_data=0x0000, element_data=0x000, all pulses 0, busy=0; the 'L' is not consumed.
- Send "LF0FF\r" back-to-back -> one cycle after '\r' is sampled: led_data=0xF0FF, led_update pulses for one cycle, element_data unchanged, no parse_error.
- Send "e123\n" then "lafcd\r" -> element_data=0x123 with one element_update, then led_data=0xAFCD with one led_update; lowercase is accepted.
- Malformed inputs:
  - "LAG" -> parse_error pulses once on 'G'; the following "12\r" produces no commit; led_data unchanged.
  - "E12\r" -> parse_error on '\r', return to IDLE.
  - "L12345\r" -> parse_error on '5', no commit.
- Deassert ena mid-command after "LAA" while holding rx_valid=1 with byte 'Z' -> state is held and 'Z' is ignored. After ena=1, send "CD\r" -> led_data=0xAACD.
- Assert reset after "E12" -> no commit and no error. A following "E456\r" -> element_data=0x456.

Source files
------------

// File: rtl/input_command_parser_if.sv
// rtl/input_command_parser_if.sv - byte stream in, decoded LED/element register writes out
interface input_command_parser_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int LED_COUNT     = 16,
  parameter int ELEMENT_COUNT = 12
);
  logic [DATA_WIDTH-1:0]    rx_data;
  logic                     rx_valid;
  logic [LED_COUNT-1:0]     led_data;
  logic                     led_update;
  logic [ELEMENT_COUNT-1:0] element_data;
  logic                     element_update;
  logic                     parse_error;
  logic                     busy;

  modport master (
    output rx_data, rx_valid,
    input  led_data, led_update, element_data, element_update, parse_error, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output led_data, led_update, element_data, element_update, parse_error, busy
  );
endinterface

// File: rtl/input_command_parser.sv
// rtl/input_command_parser.sv - decodes ASCII "L<hex>"/"E<hex>" commands into register writes
module input_command_parser #(
  parameter int DATA_WIDTH    = 8,
  parameter int LED_COUNT     = 16,
  parameter int ELEMENT_COUNT = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input_command_parser_if.slave bus
);
  localparam int LED_DIGITS  = (LED_COUNT + 3) / 4;
  localparam int ELEM_DIGITS = (ELEMENT_COUNT + 3) / 4;
  localparam int MAX_DIGITS  = (LED_DIGITS > ELEM_DIGITS) ? LED_DIGITS : ELEM_DIGITS;
  localparam int ACC_W       = 4 * MAX_DIGITS;
  localparam int CNT_W       = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_DIGITS, S_TERM, S_DISCARD} state_t;

  state_t                   state, state_n;
  logic [ACC_W-1:0]         acc, acc_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic                     tgt_led, tgt_led_n;
  logic [LED_COUNT-1:0]     led_q, led_n;
  logic [ELEMENT_COUNT-1:0] elem_q, elem_n;
  logic                     led_upd_q, led_upd_n;
  logic                     elem_upd_q, elem_upd_n;
  logic                     err_q, err_n;

  logic [7:0]       rx_byte;
  logic             is_term, is_space, is_l, is_e, is_hex;
  logic [3:0]       nibble;
  logic [ACC_W+3:0] acc_shift;

  assign rx_byte = bus.rx_data[7:0];

  if (DATA_WIDTH > 8) begin : g_upper
    logic unused_upper;
    assign unused_upper = ^bus.rx_data[DATA_WIDTH-1:8];
  end

  always_comb begin
    is_term  = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
    is_space = (rx_byte == 8'h20);
    is_l     = (rx_byte == 8'h4C) || (rx_byte == 8'h6C);
    is_e     = (rx_byte == 8'h45) || (rx_byte == 8'h65);
    is_hex   = 1'b0;
    nibble   = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = rx_byte[3:0] + 4'd9;
    end
  end

  // Shifting through a wider vector keeps this legal even for a one-digit accumulator.
  assign acc_shift = {acc, nibble};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (ena) begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (bus.rx_valid) begin
      case (state)
        S_IDLE: begin
          if (is_l || is_e) state_n = S_DIGITS;
          else if (!(is_term || is_space)) state_n = S_DISCARD;
        end
        S_DIGITS: begin
          if (is_hex) state_n = (cnt == CNT_W'(1)) ? S_TERM : S_DIGITS;
          else if (is_term) state_n = S_IDLE;
          else state_n = S_DISCARD;
        end
        S_TERM: begin
          if (is_term) state_n = S_IDLE;
          else state_n = S_DISCARD;
        end
        default: begin
          if (is_term) state_n = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    acc_n      = acc;
    cnt_n      = cnt;
    tgt_led_n  = tgt_led;
    led_n      = led_q;
    elem_n     = elem_q;
    led_upd_n  = 1'b0;
    elem_upd_n = 1'b0;
    err_n      = 1'b0;
    if (bus.rx_valid) begin
      case (state)
        S_IDLE: begin
          if (is_l) begin
            tgt_led_n = 1'b1;
            cnt_n     = CNT_W'(LED_DIGITS);
            acc_n     = '0;
          end else if (is_e) begin
            tgt_led_n = 1'b0;
            cnt_n     = CNT_W'(ELEM_DIGITS);
            acc_n     = '0;
          end else if (!(is_term || is_space)) begin
            err_n = 1'b1;
          end
        end
        S_DIGITS: begin
          if (is_hex) begin
            acc_n = acc_shift[ACC_W-1:0];
            cnt_n = cnt - CNT_W'(1);
          end else begin
            err_n = 1'b1;
          end
        end
        S_TERM: begin
          // High bits of the first digit fall away when the width is not a nibble multiple.
          if (is_term && tgt_led) begin
            led_n     = acc[LED_COUNT-1:0];
            led_upd_n = 1'b1;
          end else if (is_term) begin
            elem_n     = acc[ELEMENT_COUNT-1:0];
            elem_upd_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      cnt        <= '0;
      tgt_led    <= 1'b0;
      led_q      <= '0;
      elem_q     <= '0;
      led_upd_q  <= 1'b0;
      elem_upd_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (ena) begin
      acc        <= acc_n;
      cnt        <= cnt_n;
      tgt_led    <= tgt_led_n;
      led_q      <= led_n;
      elem_q     <= elem_n;
      led_upd_q  <= led_upd_n;
      elem_upd_q <= elem_upd_n;
      err_q      <= err_n;
    end else begin
      led_upd_q  <= 1'b0;
      elem_upd_q <= 1'b0;
      err_q      <= 1'b0;
    end
  end

  assign bus.led_data       = led_q;
  assign bus.led_update     = led_upd_q;
  assign bus.element_data   = elem_q;
  assign bus.element_update = elem_upd_q;
  assign bus.parse_error    = err_q;
  assign bus.busy           = (state != S_IDLE);
endmodule

// File: tb/tb_input_command_parser.sv
// tb/tb_input_command_parser.sv - directed-vector bench for input_command_parser
module tb_input_command_parser;
  logic clk = 1'b0;
  logic reset;
  logic ena;
  int   errors = 0;
  int   checks = 0;
  int   n_led = 0;
  int   n_elem = 0;
  int   n_err = 0;

  input_command_parser_if bus ();

  input_command_parser dut (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    n_led  += int'(bus.led_update);
    n_elem += int'(bus.element_update);
    n_err  += int'(bus.parse_error);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic clr();
    n_led  = 0;
    n_elem = 0;
    n_err  = 0;
  endtask

  initial begin
    reset        = 1'b1;
    ena          = 1'b1;
    bus.rx_data  = 8'h4C;
    bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    reset        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_led", 32'(bus.led_data), 32'h0000);
    check("rst_elem", 32'(bus.element_data), 32'h000);
    check("rst_pulses", {29'b0, bus.led_update, bus.element_update, bus.parse_error}, 0);
    @(negedge clk);
    check("rst_l_not_consumed", 32'(bus.busy), 0);

    clr();
    send_str("LF0FF");
    put(8'h0D);
    gap();
    check("led_f0ff", 32'(bus.led_data), 32'hF0FF);
    check("led_f0ff_upd", 32'(bus.led_update), 1);
    check("led_f0ff_elem", 32'(bus.element_data), 32'h000);
    check("led_f0ff_err", 32'(bus.parse_error), 0);
    gap();
    check("led_f0ff_upd_end", 32'(bus.led_update), 0);
    check("led_f0ff_nupd", 32'(n_led), 1);

    clr();
    send_str("e123");
    put(8'h0A);
    send_str("lafcd");
    put(8'h0D);
    gap();
    gap();
    check("elem_123", 32'(bus.element_data), 32'h123);
    check("led_afcd", 32'(bus.led_data), 32'hAFCD);
    check("b2b_nelem", 32'(n_elem), 1);
    check("b2b_nled", 32'(n_led), 1);
    check("b2b_nerr", 32'(n_err), 0);

    clr();
    send_str("LAG12");
    put(8'h0D);
    gap();
    gap();
    check("lag_nerr", 32'(n_err), 1);
    check("lag_nled", 32'(n_led), 0);
    check("lag_led", 32'(bus.led_data), 32'hAFCD);
    check("lag_busy", 32'(bus.busy), 0);

    clr();
    send_str("E12");
    put(8'h0D);
    gap();
    check("short_err", 32'(bus.parse_error), 1);
    check("short_idle", 32'(bus.busy), 0);
    gap();
    check("short_err_end", 32'(bus.parse_error), 0);
    check("short_elem", 32'(bus.element_data), 32'h123);

    clr();
    send_str("L1234");
    put(8'h35);
    gap();
    check("long_err", 32'(bus.parse_error), 1);
    check("long_discard", 32'(bus.busy), 1);
    put(8'h0D);
    gap();
    gap();
    check("long_nerr", 32'(n_err), 1);
    check("long_nled", 32'(n_led), 0);
    check("long_led", 32'(bus.led_data), 32'hAFCD);

    clr();
    send_str("LAA");
    @(negedge clk);
    ena          = 1'b0;
    bus.rx_data  = 8'h5A;
    bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("ena_hold_busy", 32'(bus.busy), 1);
    check("ena_hold_nerr", 32'(n_err), 0);
    ena          = 1'b1;
    bus.rx_valid = 1'b0;
    send_str("CD");
    put(8'h0D);
    gap();
    check("ena_led_aacd", 32'(bus.led_data), 32'hAACD);
    check("ena_led_upd", 32'(bus.led_update), 1);
    check("ena_nerr", 32'(n_err), 0);

    clr();
    send_str("E123");
    put(8'h0D);
    gap();
    check("same_val_upd", 32'(bus.element_update), 1);
    check("same_val_elem", 32'(bus.element_data), 32'h123);
    ena = 1'b0;
    @(negedge clk);
    check("ena_pulse_drop", 32'(bus.element_update), 0);
    check("ena_pulse_nelem", 32'(n_elem), 1);
    ena = 1'b1;

    send_str("E12");
    @(negedge clk);
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    clr();
    gap();
    gap();
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_nerr", 32'(n_err), 0);
    check("mid_rst_nelem", 32'(n_elem), 0);
    check("mid_rst_elem", 32'(bus.element_data), 32'h000);
    check("mid_rst_led", 32'(bus.led_data), 32'h0000);
    send_str("E456");
    put(8'h0D);
    gap();
    check("elem_456", 32'(bus.element_data), 32'h456);
    check("elem_456_upd", 32'(bus.element_update), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
